// File: rtl/pe_serial_n.sv
// Serial-I/O Jacobi processing element: loads four neighbour words bit-serially,
// averages them into the local solution and streams the solution out MSB first.
// Optional build macro PE_DIRICHLET_EN adds a 'fixed' input for boundary nodes.
module pe_serial_n #(
  parameter int WIDTH = 8,
  parameter int TOL   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic             shift,
  input  logic             update,
  input  logic             read,
  input  logic             left,
  input  logic             top,
  input  logic             right,
  input  logic             down,
`ifdef PE_DIRICHLET_EN
  input  logic             fixed,
`endif
  output logic             solution,
  output logic [WIDTH-1:0] residue,
  output logic             converged,
  output logic             busy,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] TOL_W = WIDTH'(TOL);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CALC = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] l_q, t_q, r_q, d_q;
  logic [WIDTH-1:0] sol_q, res_q;
  logic [CW-1:0]    cnt_q, oidx_q;
  logic             conv_q, ovf_q;
  logic             fix_q, dload_q;

  logic             load_req_s, full_s, upd_ok_s, shift_en_s, ovf_set_s, out_last_s;
  logic [WIDTH+1:0] sum_s;
  logic [WIDTH-1:0] new_s, diff_s, sol_sh_s;
  logic [CW-1:0]    bit_idx_s;
  logic             fixed_s;

`ifdef PE_DIRICHLET_EN
  assign fixed_s = fixed;
`else
  assign fixed_s = 1'b0;
`endif

  assign load_req_s = mode & shift;
  assign full_s     = (cnt_q == CW'(WIDTH));
  assign upd_ok_s   = (state_q == S_LOAD) & update & full_s;
  // An accepted update swallows a coincident shift; a rejected one does not.
  assign shift_en_s = load_req_s & ~full_s & ~upd_ok_s &
                      ((state_q == S_IDLE) | (state_q == S_LOAD));
  assign ovf_set_s  = load_req_s & full_s & ~upd_ok_s & (state_q == S_LOAD);
  assign out_last_s = (oidx_q == CW'(WIDTH - 1));

  assign sum_s  = {2'b00, l_q} + {2'b00, t_q} + {2'b00, r_q} + {2'b00, d_q};
  assign new_s  = sum_s[WIDTH+1:2];
  assign diff_s = (new_s >= sol_q) ? (new_s - sol_q) : (sol_q - new_s);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (load_req_s) begin
          state_d = S_LOAD;
        end else if (read && !mode) begin
          state_d = S_OUT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (upd_ok_s) begin
          state_d = S_CALC;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_CALC: state_d = S_IDLE;
      S_OUT: begin
        if (out_last_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_OUT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy      = 1'b0;
    solution  = 1'b0;
    bit_idx_s = CW'(WIDTH - 1) - oidx_q;
    sol_sh_s  = sol_q >> bit_idx_s;
    case (state_q)
      S_CALC:  busy = 1'b1;
      S_OUT: begin
        busy     = 1'b1;
        solution = sol_sh_s[0];
      end
      default: begin
        busy     = 1'b0;
        solution = 1'b0;
      end
    endcase
  end

  // Datapath: neighbour shift registers, solution, residue and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_q     <= '0;
      t_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      sol_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      oidx_q  <= '0;
      conv_q  <= 1'b0;
      ovf_q   <= 1'b0;
      fix_q   <= 1'b0;
      dload_q <= 1'b0;
    end else begin
      if (shift_en_s) begin
        l_q   <= {l_q[WIDTH-2:0], left};
        t_q   <= {t_q[WIDTH-2:0], top};
        r_q   <= {r_q[WIDTH-2:0], right};
        d_q   <= {d_q[WIDTH-2:0], down};
        cnt_q <= cnt_q + CW'(1);
      end
      if (ovf_set_s) begin
        ovf_q <= 1'b1;
      end
      if (upd_ok_s) begin
        fix_q   <= fixed_s;
        dload_q <= fixed_s & mode;
      end
      if (state_q == S_CALC) begin
        cnt_q <= '0;
        if (fix_q) begin
          res_q  <= '0;
          conv_q <= 1'b1;
          if (dload_q) begin
            sol_q <= l_q;
          end
        end else begin
          res_q  <= diff_s;
          sol_q  <= new_s;
          conv_q <= (diff_s <= TOL_W);
        end
      end
      if (state_q == S_OUT && !out_last_s) begin
        oidx_q <= oidx_q + CW'(1);
      end else begin
        oidx_q <= '0;
      end
    end
  end

  assign residue   = res_q;
  assign converged = conv_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_pe_serial_n.sv
// Randomised and directed bench for pe_serial_n against a behavioural model.
module tb_pe_serial_n;
  localparam int W   = 8;
  localparam int TOL = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mode = 1'b0, shift = 1'b0, update = 1'b0, read = 1'b0;
  logic left = 1'b0, top = 1'b0, right = 1'b0, down = 1'b0;
  logic solution, converged, busy, overflow;
  logic [W-1:0] residue;

  pe_serial_n #(.WIDTH(W), .TOL(TOL)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .shift(shift), .update(update),
    .read(read), .left(left), .top(top), .right(right), .down(down),
`ifdef PE_DIRICHLET_EN
    .fixed(1'b0),
`endif
    .solution(solution), .residue(residue), .converged(converged),
    .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 loading, 2 compute pending, 3 reading out
  int m_w[4];
  int m_cnt, m_phase, m_rem, m_sol, m_res;
  bit m_conv, m_ovf;

  task automatic model_reset();
    for (int k = 0; k < 4; k++) m_w[k] = 0;
    m_cnt = 0; m_phase = 0; m_rem = 0; m_sol = 0; m_res = 0;
    m_conv = 0; m_ovf = 0;
  endtask

  task automatic model_push(input bit [3:0] b);
    for (int k = 0; k < 4; k++) m_w[k] = (m_w[k] * 2 + b[3-k]) % (1 << W);
  endtask

  task automatic model_step(input bit md, input bit sh, input bit up, input bit rd, input bit [3:0] b);
    int nv;
    case (m_phase)
      0: begin
        if (md && sh) begin
          model_push(b); m_cnt = 1; m_phase = 1;
        end else if (rd && !md) begin
          m_phase = 3; m_rem = W;
        end
      end
      1: begin
        if (up && m_cnt == W) m_phase = 2;
        else if (md && sh) begin
          if (m_cnt < W) begin model_push(b); m_cnt++; end
          else m_ovf = 1;
        end
      end
      2: begin
        nv = (m_w[0] + m_w[1] + m_w[2] + m_w[3]) / 4;
        m_res = (nv > m_sol) ? nv - m_sol : m_sol - nv;
        m_sol = nv;
        m_conv = (m_res <= TOL);
        m_cnt = 0;
        m_phase = 0;
      end
      default: begin
        m_rem--;
        if (m_rem == 0) m_phase = 0;
      end
    endcase
  endtask

  task automatic cyc(input bit md, input bit sh, input bit up, input bit rd, input bit [3:0] b);
    int exp_bit;
    mode = md; shift = sh; update = up; read = rd;
    left = b[3]; top = b[2]; right = b[1]; down = b[0];
    @(posedge clk);
    model_step(md, sh, up, rd, b);
    #1;
    exp_bit = (m_phase == 3) ? ((m_sol >> (m_rem - 1)) & 1) : 0;
    chk("solution", 64'(solution), 64'(exp_bit));
    chk("busy", 64'(busy), 64'(m_phase == 2 || m_phase == 3));
    chk("residue", 64'(residue), 64'(m_res));
    chk("converged", 64'(converged), 64'(m_conv));
    chk("overflow", 64'(overflow), 64'(m_ovf));
  endtask

  task automatic load(input int l, input int t, input int r, input int d, input int n);
    int idx;
    bit [3:0] b;
    for (int i = 0; i < n; i++) begin
      idx = W - 1 - i;
      if (idx >= 0) b = {1'((l >> idx) & 1), 1'((t >> idx) & 1), 1'((r >> idx) & 1), 1'((d >> idx) & 1)};
      else b = 4'b0000;
      cyc(1'b1, 1'b1, 1'b0, 1'b0, b);
    end
  endtask

  task automatic upd();
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
  endtask

  initial begin
    int guard;
    model_reset();
    #12;
    chk("rst_solution", 64'(solution), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_residue", 64'(residue), 64'd0);
    chk("rst_conv", 64'(converged), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    @(negedge clk) rst_n = 1'b1;

    load(8'hE4, 8'hE7, 8'hB0, 8'hCC, 8);
    upd();
    chk("first_res", 64'(residue), 64'hD1);
    chk("first_conv", 64'(converged), 64'd0);

    load(8'hE4, 8'hE7, 8'hB0, 8'hCC, 8);
    upd();
    chk("second_res", 64'(residue), 64'h00);
    chk("second_conv", 64'(converged), 64'd1);

    cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
    for (int i = 0; i < W; i++) begin
      chk("read_bit", 64'(solution), 64'((8'hD1 >> (W - 1 - i)) & 1));
      chk("read_busy", 64'(busy), 64'd1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    end
    chk("read_done_busy", 64'(busy), 64'd0);

    load(8'hE4, 8'hE7, 8'hB0, 8'hCC, 9);
    chk("ovf_set", 64'(overflow), 64'd1);
    upd();
    chk("ovf_res", 64'(residue), 64'h00);

    load(8'h12, 8'h34, 8'h56, 8'h78, 5);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
    chk("early_upd_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'($urandom));
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
    chk("late_upd_busy", 64'(busy), 64'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);

    for (int i = 0; i < 600; i++) begin
      cyc(1'(($urandom % 4) != 0), 1'($urandom % 2), 1'(($urandom % 6) == 0),
          1'(($urandom % 8) == 0), 4'($urandom));
    end

    // Reach idle (finishing any pending load with an update), then reset mid-readout
    guard = 0;
    while (m_phase != 0 && guard < 40) begin
      if (m_phase == 1 && m_cnt < W) cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'($urandom));
      else if (m_phase == 1) cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
      else cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
      guard++;
    end
    chk("idle_reached", 64'(m_phase), 64'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_solution", 64'(solution), 64'd0);
    chk("async_busy", 64'(busy), 64'd0);
    chk("async_residue", 64'(residue), 64'd0);
    chk("async_ovf", 64'(overflow), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
    for (int i = 0; i < W + 1; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/pe_serial_n.md
PE_SERIAL_N -- requirements
Module: pe_serial_n

Interface
REQ-001 Parameter WIDTH, default 8, bit width of solution, neighbour and residue words (4..32).
REQ-002 Parameter TOL, default 0, convergence threshold compared against the residue.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 mode  input  1  1 = neighbour load phase, 0 = compute/idle phase.
REQ-006 shift  input  1  strobe: sample one serial bit from each neighbour input.
REQ-007 update  input  1  strobe: commit Jacobi update from loaded neighbours.
REQ-008 read  input  1  strobe: start serial readout of the solution.
REQ-009 left, top, right, down  input  1 each  serial neighbour bits, MSB first.
REQ-010 solution  output  1  serial solution bit, MSB first, valid while busy in OUT.
REQ-011 residue  output  WIDTH  |new - old| from the last update.
REQ-012 converged  output  1  1 when last residue <= TOL.
REQ-013 busy  output  1  high in CALC and OUT states.
REQ-014 overflow  output  1  sticky: shift received with the neighbour word already full.

Function
REQ-015 FSM states IDLE, LOAD, CALC, OUT; reset state IDLE.
REQ-016 IDLE: mode=1 and shift -> LOAD, shifts the first bit in, bit count = 1.
REQ-017 LOAD: each mode=1 and shift shifts one bit into each of four WIDTH-bit registers (left-shift, LSB receives input); bit count increments, saturating at WIDTH.
REQ-018 Shift with bit count = WIDTH: registers unchanged, overflow set.
REQ-019 update with bit count = WIDTH -> CALC for exactly one cycle; update with bit count < WIDTH is ignored, state unchanged.
REQ-020 CALC: sum = l+t+r+d in WIDTH+2 bits; new = sum >> 2 (truncate); residue <= |new - sol|; sol <= new; converged <= (residue_new <= TOL); bit count cleared; next state IDLE.
REQ-021 update and shift in the same cycle: update wins, shift bit dropped.
REQ-022 IDLE: read (mode=0) -> OUT; solution drives sol[WIDTH-1] in the first OUT cycle, then next-lower bit each cycle, WIDTH cycles total, then IDLE.
REQ-023 OUT: shift, update and read are ignored; sol is not modified.
REQ-024 read and (mode=1 and shift) both asserted in IDLE: load wins.
REQ-025 solution = 0 outside OUT.
REQ-026 mode dropping to 0 in LOAD holds the partial word; mode returning to 1 resumes shifting.
REQ-027 Latency: update strobe at cycle n -> residue/converged/sol valid at cycle n+2.

Reset
REQ-028 rst_n low at any time, mid-operation included, forces IDLE, sol = 0, neighbour registers = 0, bit count = 0, residue = 0, converged = 0, busy = 0, overflow = 0, solution = 0.
REQ-029 Only reset clears overflow.

Configuration
REQ-030 Macro PE_DIRICHLET_EN defined: adds input port fixed (1 bit); fixed=1 in CALC leaves sol unchanged, forces residue = 0 and converged = 1, and loads sol from the left register when update occurs with fixed=1 and mode=1.
REQ-031 Macro undefined: no fixed port; all nodes update per REQ-020.

Verification
REQ-032 WIDTH=8, load left=0xE4, top=0xE7, right=0xB0, down=0xCC MSB first, update -> sol=0xD1, residue=0xD1, converged=0.
REQ-033 Reload the same values, update again -> sol=0xD1, residue=0x00, converged=1.
REQ-034 read after REQ-033 -> solution bits 1,1,0,1,0,0,0,1 on 8 consecutive cycles, busy high 8 cycles.
REQ-035 Nine shifts before update -> overflow=1; update uses the first 8 bits, sol=0xD1.
REQ-036 update after 5 shifts -> ignored, sol and residue unchanged, FSM stays LOAD.
REQ-037 rst_n low during OUT cycle 3 -> solution=0, busy=0, sol=0 immediately, no clock edge required.
